alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised, registered successor to the 4-bit combinational ALU. It keeps the same opcode set: ADD, SUB, MULT, AND, OR, XOR. Differences from the 4-bit block:
- operand width is generic;
- multiply is an iterative shift-add engine;
- operands and results use valid/ready handshakes;
- outputs include zero and illegal-op flags.

It sits between the operand/opcode source and the result consumer (e.g. BCD display path), and holds each result until the consumer takes it.

Parameters:
WIDTH, 4, operand width in bits (>=2); result width is 2*WIDTH.

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  operand/opcode presented
in_ready  output  1  block can accept a new operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carry_in  input  1  carry for ADD; borrow for SUB
op_code  input  3  0 ADD, 1 SUB, 2 MULT, 4 AND, 5 OR, 6 XOR; 3 and 7 illegal
out_valid  output  1  result registers hold a valid result
out_ready  input  1  consumer takes the result
y  output  2*WIDTH  result
carry_out  output  1  ADD carry / SUB borrow
overflow  output  1  signed two's-complement overflow (ADD/SUB)
zero  output  1  y == 0
illegal  output  1  op_code was 3 or 7

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n low at a clk edge):
  - state IDLE;
  - out_valid=0; y, carry_out, overflow and illegal = 0; zero=1;
  - multiplier counter and accumulator cleared;
  - in_ready=1 from the first cycle after reset.
  - Reset during MUL aborts the operation; no result is produced.
- States: IDLE, MUL, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational and low during MUL.
- Accept occurs when in_valid && in_ready at an edge; a, b, carry_in and op_code are captured at that edge.
- Simple ops (ADD, SUB, logic, illegal): result registered at the accept edge; state goes to DONE, so out_valid is high the next cycle (latency 1).
- ADD:
  - {carry_out, y[WIDTH-1:0]} = a + b + carry_in;
  - overflow = (a[MSB]==b[MSB]) && (y[MSB]!=a[MSB]).
- SUB:
  - y[WIDTH-1:0] = a - b - carry_in;
  - carry_out = 1 when a < b + carry_in (borrow);
  - overflow = (a[MSB]!=b[MSB]) && (y[MSB]!=a[MSB]).
- AND/OR/XOR: bitwise on WIDTH bits.
- Illegal op: y=0, illegal=1.
- For every non-MUL op, y[2*WIDTH-1:WIDTH]=0.
- Flag clearing: carry_out=0 and overflow=0 for MUL and logic ops. illegal=0 for legal ops.
- MULT (unsigned, shift-add, one partial-product bit per cycle):
  - accept edge: state goes to MUL, counter=0;
  - WIDTH cycles in MUL; the final step's edge writes y = a*b and moves to DONE;
  - out_valid asserts WIDTH cycles after the accept edge.
- DONE:
  - y and all flags are held stable while out_ready is low;
  - on out_ready with no new accept: state goes to IDLE and out_valid drops;
  - on out_ready with a simultaneous accept: a simple op goes DONE→DONE with the new result (out_valid stays high, one result per cycle); MULT goes to MUL.
- zero is registered together with y, and always equals (y==0).
- No accept is possible while a MULT is in progress. in_valid during MUL is ignored, not queued.

Decomposition:
- Shared package alu_pkg: localparams OP_ADD=3'd0, OP_SUB=3'd1, OP_MUL=3'd2, OP_AND=3'd4, OP_OR=3'd5, OP_XOR=3'd6; state encoding for IDLE/MUL/DONE.
- One sub-module, alu_seq_mul (WIDTH):
  - inputs clk, rst_n, start, a, b;
  - outputs busy, done (1-cycle pulse), p[2*WIDTH-1:0];
  - holds the shift-add accumulator and counter.
- alu_seq contains the FSM, handshake, simple-op datapath and output registers.

Test Plan:
1. WIDTH=4, ADD a=7, b=9, carry_in=1, out_ready=1 → one cycle later out_valid=1, y=8'h01, carry_out=1, overflow=0, zero=0. ADD a=7, b=1, carry_in=0 → y=8'h08, overflow=1, carry_out=0.
2. SUB a=3, b=5, carry_in=0 → y=8'h0E, carry_out=1, overflow=0. SUB a=5, b=5, carry_in=0 → y=0, zero=1, carry_out=0.
3. MULT a=15, b=15 → in_ready low for 4 cycles, out_valid exactly 4 cycles after accept, y=8'hE1, carry_out=0. MULT a=0, b=9 → y=0, zero=1.
4. Backpressure: XOR a=4'hA, b=4'h6, out_ready held low 3 cycles → y=8'h0C stable, out_valid=1, in_ready=0 throughout; output released on the cycle out_ready rises.
5. Back-to-back: in_valid and out_ready held high with AND, OR, XOR streams → one result per cycle, out_valid never drops; illegal op_code 3 in the stream → y=0, illegal=1, stream continues.
6. rst_n low for one edge during the 2nd MUL cycle → next cycle state IDLE, out_valid=0, y=0, zero=1, in_ready=1; no stale product later appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the registered ALU and its shift-add multiplier.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op != 3'd3) && (op != 3'd7);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier: one partial-product bit per cycle, WIDTH cycles per product.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = acc;
    if (b_sh[0]) begin
      acc_next = acc + a_sh;
    end
  end

  // done and p are combinational so the owner can latch the product on the
  // same edge that performs the final step, giving exactly WIDTH cycles.
  assign done = busy && (cnt == LAST);
  assign p    = acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      acc  <= '0;
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
    end else if (busy) begin
      acc  <= acc_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
      if (cnt == LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: single-cycle add/sub/logic ops, iterative multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 carry_in,
  input  logic [2:0]           op_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 zero,
  output logic                 illegal
);

  localparam int unsigned MSB = WIDTH - 1;

  state_t state;

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_p;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   res_lo;
  logic               res_c;
  logic               res_v;
  logic               res_ill;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_code == OP_MUL);

  // Extra top bit of the extended difference is the borrow.
  assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};

  always_comb begin
    res_lo  = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_ill = !op_is_legal(op_code);
    case (op_code)
      OP_ADD: begin
        res_lo = sum[WIDTH-1:0];
        res_c  = sum[WIDTH];
        res_v  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res_lo = diff[WIDTH-1:0];
        res_c  = diff[WIDTH];
        res_v  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND:  res_lo = a & b;
      OP_OR:   res_lo = a | b;
      OP_XOR:  res_lo = a ^ b;
      default: res_lo = '0;
    endcase
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (op_code == OP_MUL) begin
              state     <= ST_MUL;
              out_valid <= 1'b0;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              y         <= {{WIDTH{1'b0}}, res_lo};
              carry_out <= res_c;
              overflow  <= res_v;
              zero      <= (res_lo == '0);
              illegal   <= res_ill;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            y         <= mul_p;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= (mul_p == '0);
            illegal   <= 1'b0;
          end else if (!mul_busy) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
